pad_cfg_ctrl: RTL and testbench
===============================

PAD_CFG_CTRL -- requirements
Module: pad_cfg_ctrl

Interface
REQ-001 SHALL have parameter NGPIO, default 9: pads per side.
REQ-002 SHALL have parameter CFGW, default 8: config bits per pad.
REQ-003 SHALL have parameter SETTLE, default 4: quiesce/release hold cycles, legal range 1..15.
REQ-004 SHALL have port clk_i, input, 1: the single clock.
REQ-005 SHALL have port rst_i, input, 1: reset, synchronous, active-high.
REQ-006 SHALL have port req_valid_i, input, 1: config write request.
REQ-007 SHALL have port req_ready_o, output, 1: write accepted when valid and ready are both high.
REQ-008 SHALL have port req_side_i, input, 2: target side, 0=no, 1=so, 2=ea, 3=we.
REQ-009 SHALL have port req_pad_i, input, 4: pad index.
REQ-010 SHALL have port req_cfg_i, input, CFGW: pad config value.
REQ-011 SHALL have port commit_i, input, 1: apply shadow config to the pads.
REQ-012 SHALL have port busy_o, output, 1: commit sequence in progress.
REQ-013 SHALL have port done_o, output, 1: one-cycle pulse at end of a commit.
REQ-014 SHALL have port err_o, output, 1: sticky out-of-range pad write flag, cleared by reset only.
REQ-015 SHALL have ports {no,so,ea,we}_oen_i and {no,so,ea,we}_ie_i, input, NGPIO each: core output-enable-bar and input-enable.
REQ-016 SHALL have ports {no,so,ea,we}_oen_o, {no,so,ea,we}_ie_o (output, NGPIO each) and {no,so,ea,we}_cfg_o (output, NGPIO*CFGW each): signals driven to the padring.

Function
REQ-017 SHALL hold, per side, a shadow config array, a live config array and a dirty bit.
REQ-018 SHALL, on an accepted write with req_pad_i<NGPIO, write req_cfg_i into shadow[side][pad] and set dirty[side].
REQ-019 SHALL, on an accepted write with req_pad_i>=NGPIO, leave shadow and dirty unchanged and set err_o.
REQ-020 SHALL drive pad p of side s from bits [p*CFGW +: CFGW] of the live config on s_cfg_o.
REQ-021 SHALL implement the FSM states IDLE, QUIESCE, APPLY, RELEASE and DONE.
REQ-022 SHALL, in IDLE, drive req_ready_o=1; in every other state it SHALL drive req_ready_o=0 and busy_o=1.
REQ-023 SHALL, on commit_i in IDLE with any dirty bit set, latch the dirty mask as the commit mask and go to QUIESCE.
REQ-024 SHALL, on commit_i in IDLE with no dirty bit set, go directly to DONE.
REQ-025 SHALL, when commit_i and an accepted write coincide in IDLE, include that write in the commit mask.
REQ-026 SHALL, in QUIESCE and RELEASE, force oen_o=all-ones and ie_o=all-zeros on every masked side; unmasked sides pass oen_i/ie_i through unchanged.
REQ-027 SHALL remain in QUIESCE for exactly SETTLE cycles and then go to APPLY.
REQ-028 SHALL, in APPLY (one cycle), copy shadow to live and clear dirty for each masked side, keep the sides forced, and go to RELEASE.
REQ-029 SHALL remain in RELEASE for exactly SETTLE cycles and then go to DONE.
REQ-030 SHALL, in DONE, pulse done_o for one cycle and return to IDLE.
REQ-031 SHALL ignore commit_i outside IDLE.
REQ-032 SHALL make live cfg_o change only at the APPLY edge.
REQ-033 SHALL give a commit latency of 2*SETTLE+2 cycles from commit to done_o.

Reset
REQ-034 SHALL, while rst_i is high on a clock edge, return the FSM to IDLE, clear shadow, live, dirty, mask, counter and err_o, and drive done_o=0 and busy_o=0; req_ready_o SHALL return to 1 on the cycle after the reset edge.
REQ-035 SHALL abort a commit when reset is asserted mid-commit, with no partial live update persisting; oen_o/ie_o then pass through from the core.

Configuration
REQ-036 SHALL, with PAD_CFG_CTRL_READBACK_EN defined, add inputs rd_side_i[1:0] and rd_pad_i[3:0] and output rd_cfg_o[CFGW], where rd_cfg_o is the registered live config for that side/pad with 1-cycle latency, and 0 when rd_pad_i>=NGPIO.
REQ-037 SHALL, without PAD_CFG_CTRL_READBACK_EN, omit rd_side_i, rd_pad_i and rd_cfg_o and all readback logic.

Structure
REQ-038 SHALL place the side encoding enum, the FSM state enum and the NGPIO/CFGW defaults in the shared package zerosoc_pad_pkg.
REQ-039 SHALL instantiate sub-module pad_cfg_side four times, each holding shadow, live, dirty and the oen/ie override for one side.

Verification
REQ-040 SHALL cover: write no pad 3 cfg 0xA5, then commit -> no_cfg_o[31:24]=0xA5 exactly at the APPLY edge, and done_o 10 cycles after commit with SETTLE=4.
REQ-041 SHALL cover: dirty ea only, commit -> ea_oen_o=9'h1FF and ea_ie_o=0 for 9 cycles, while no/so/we pass through the core signals.
REQ-042 SHALL cover: write we pad 9 -> err_o=1, no shadow change, and a following commit takes the no-dirty path with done_o on the next cycle.
REQ-043 SHALL cover: write and commit in the same IDLE cycle -> the write is applied by that commit.
REQ-044 SHALL cover: rst_i asserted in RELEASE -> next cycle all cfg_o=0, oen/ie pass through, req_ready_o=1.
REQ-045 SHALL cover: with READBACK_EN, read so pad 0 after committing 0x3C -> rd_cfg_o=0x3C one cycle later.

Source files
------------

// File: rtl/zerosoc_pad_pkg.sv
// Shared types and defaults for the zerosoc padring config controller.
package zerosoc_pad_pkg;

   localparam int NGPIO_DEF  = 9;
   localparam int CFGW_DEF   = 8;
   localparam int SETTLE_DEF = 4;

   typedef enum logic [1:0] {
      SIDE_NO = 2'd0,
      SIDE_SO = 2'd1,
      SIDE_EA = 2'd2,
      SIDE_WE = 2'd3
   } side_e;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_QUIESCE = 3'd1,
      ST_APPLY   = 3'd2,
      ST_RELEASE = 3'd3,
      ST_DONE    = 3'd4
   } state_e;

endpackage

// File: rtl/pad_cfg_ctrl_if.sv
// Config write request handshake for pad_cfg_ctrl.
interface pad_cfg_ctrl_if
   import zerosoc_pad_pkg::*;
#(
   parameter int CFGW = CFGW_DEF
);
   logic            req_valid_i;
   logic            req_ready_o;
   logic [1:0]      req_side_i;
   logic [3:0]      req_pad_i;
   logic [CFGW-1:0] req_cfg_i;

   modport master (
      output req_valid_i, req_side_i, req_pad_i, req_cfg_i,
      input  req_ready_o
   );

   modport slave (
      input  req_valid_i, req_side_i, req_pad_i, req_cfg_i,
      output req_ready_o
   );
endinterface

// File: rtl/pad_cfg_side.sv
// One padring side: shadow/live config, dirty flag and oen/ie override.
module pad_cfg_side
   import zerosoc_pad_pkg::*;
#(
   parameter int NGPIO = NGPIO_DEF,
   parameter int CFGW  = CFGW_DEF
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  i_wr,
   input  logic [3:0]            i_pad,
   input  logic [CFGW-1:0]       i_cfg,
   input  logic                  i_apply,
   input  logic                  i_force,
   input  logic [NGPIO-1:0]      i_oen,
   input  logic [NGPIO-1:0]      i_ie,
   output logic [NGPIO-1:0]      o_oen,
   output logic [NGPIO-1:0]      o_ie,
   output logic [NGPIO*CFGW-1:0] o_cfg,
   output logic                  o_dirty
);

   logic [NGPIO*CFGW-1:0] r_shadow;
   logic [NGPIO*CFGW-1:0] r_live;
   logic                  r_dirty;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_shadow <= '0;
         r_live   <= '0;
         r_dirty  <= 1'b0;
      end else begin
         if (i_wr) begin
            for (int p = 0; p < NGPIO; p++) begin
               if (i_pad == 4'(p)) r_shadow[p*CFGW +: CFGW] <= i_cfg;
            end
            r_dirty <= 1'b1;
         end
         if (i_apply) begin
            r_live  <= r_shadow;
            r_dirty <= 1'b0;
         end
      end
   end

   assign o_oen   = i_force ? '1 : i_oen;
   assign o_ie    = i_force ? '0 : i_ie;
   assign o_cfg   = r_live;
   assign o_dirty = r_dirty;

endmodule

// File: rtl/pad_cfg_ctrl.sv
// Padring config controller with quiesce/apply/release commit sequence.
// Optional readback port enabled by PAD_CFG_CTRL_READBACK_EN.
module pad_cfg_ctrl
   import zerosoc_pad_pkg::*;
#(
   parameter int NGPIO  = NGPIO_DEF,
   parameter int CFGW   = CFGW_DEF,
   parameter int SETTLE = SETTLE_DEF
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   pad_cfg_ctrl_if.slave         req,
   input  logic                  commit_i,
   output logic                  busy_o,
   output logic                  done_o,
   output logic                  err_o,
   input  logic [NGPIO-1:0]      no_oen_i,
   input  logic [NGPIO-1:0]      so_oen_i,
   input  logic [NGPIO-1:0]      ea_oen_i,
   input  logic [NGPIO-1:0]      we_oen_i,
   input  logic [NGPIO-1:0]      no_ie_i,
   input  logic [NGPIO-1:0]      so_ie_i,
   input  logic [NGPIO-1:0]      ea_ie_i,
   input  logic [NGPIO-1:0]      we_ie_i,
   output logic [NGPIO-1:0]      no_oen_o,
   output logic [NGPIO-1:0]      so_oen_o,
   output logic [NGPIO-1:0]      ea_oen_o,
   output logic [NGPIO-1:0]      we_oen_o,
   output logic [NGPIO-1:0]      no_ie_o,
   output logic [NGPIO-1:0]      so_ie_o,
   output logic [NGPIO-1:0]      ea_ie_o,
   output logic [NGPIO-1:0]      we_ie_o,
`ifdef PAD_CFG_CTRL_READBACK_EN
   input  logic [1:0]            rd_side_i,
   input  logic [3:0]            rd_pad_i,
   output logic [CFGW-1:0]       rd_cfg_o,
`endif
   output logic [NGPIO*CFGW-1:0] no_cfg_o,
   output logic [NGPIO*CFGW-1:0] so_cfg_o,
   output logic [NGPIO*CFGW-1:0] ea_cfg_o,
   output logic [NGPIO*CFGW-1:0] we_cfg_o
);

   localparam logic [3:0] CNT_INIT = 4'(SETTLE - 1);

   state_e     r_state, w_nxt;
   logic [3:0] r_cnt, w_cnt_nxt;
   logic [3:0] r_mask, w_mask_nxt;
   logic       r_err;
   logic       w_ready;
   logic       w_acc;
   logic       w_inrng;
   side_e      w_side;
   logic [3:0] w_wr;
   logic [3:0] w_dirty;
   logic       w_hold;

   logic [NGPIO-1:0]      w_oen_i [4];
   logic [NGPIO-1:0]      w_ie_i  [4];
   logic [NGPIO-1:0]      w_oen_o [4];
   logic [NGPIO-1:0]      w_ie_o  [4];
   logic [NGPIO*CFGW-1:0] w_cfg   [4];

   assign w_acc   = req.req_valid_i & w_ready;
   assign w_inrng = 32'(req.req_pad_i) < NGPIO;
   assign w_side  = side_e'(req.req_side_i);
   assign w_hold  = (r_state == ST_QUIESCE) | (r_state == ST_APPLY) |
                    (r_state == ST_RELEASE);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_mask  <= '0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_nxt;
         r_cnt   <= w_cnt_nxt;
         r_mask  <= w_mask_nxt;
         if (w_acc && !w_inrng) r_err <= 1'b1;
      end
   end

   // A write accepted in the commit cycle joins the mask
   always_comb begin
      w_nxt      = r_state;
      w_cnt_nxt  = r_cnt;
      w_mask_nxt = r_mask;
      w_ready    = 1'b0;
      busy_o     = 1'b1;
      done_o     = 1'b0;
      unique case (r_state)
         ST_IDLE: begin
            w_ready = 1'b1;
            busy_o  = 1'b0;
            if (commit_i) begin
               if (|(w_dirty | w_wr)) begin
                  w_mask_nxt = w_dirty | w_wr;
                  w_cnt_nxt  = CNT_INIT;
                  w_nxt      = ST_QUIESCE;
               end else begin
                  w_nxt = ST_DONE;
               end
            end
         end
         ST_QUIESCE: begin
            if (r_cnt == '0) w_nxt = ST_APPLY;
            else w_cnt_nxt = r_cnt - 4'd1;
         end
         ST_APPLY: begin
            w_cnt_nxt = CNT_INIT;
            w_nxt     = ST_RELEASE;
         end
         ST_RELEASE: begin
            if (r_cnt == '0) w_nxt = ST_DONE;
            else w_cnt_nxt = r_cnt - 4'd1;
         end
         ST_DONE: begin
            done_o = 1'b1;
            w_nxt  = ST_IDLE;
         end
         default: w_nxt = ST_IDLE;
      endcase
   end

   assign req.req_ready_o = w_ready;
   assign err_o           = r_err;

   assign w_oen_i[SIDE_NO] = no_oen_i;
   assign w_oen_i[SIDE_SO] = so_oen_i;
   assign w_oen_i[SIDE_EA] = ea_oen_i;
   assign w_oen_i[SIDE_WE] = we_oen_i;
   assign w_ie_i[SIDE_NO]  = no_ie_i;
   assign w_ie_i[SIDE_SO]  = so_ie_i;
   assign w_ie_i[SIDE_EA]  = ea_ie_i;
   assign w_ie_i[SIDE_WE]  = we_ie_i;

   for (genvar s = 0; s < 4; s++) begin : g_side
      assign w_wr[s] = w_acc & w_inrng & (w_side == side_e'(s));
      pad_cfg_side #(
         .NGPIO (NGPIO),
         .CFGW  (CFGW)
      ) u_side (
         .clk_i   (clk_i),
         .rst_i   (rst_i),
         .i_wr    (w_wr[s]),
         .i_pad   (req.req_pad_i),
         .i_cfg   (req.req_cfg_i),
         .i_apply (r_mask[s] & (r_state == ST_APPLY)),
         .i_force (r_mask[s] & w_hold),
         .i_oen   (w_oen_i[s]),
         .i_ie    (w_ie_i[s]),
         .o_oen   (w_oen_o[s]),
         .o_ie    (w_ie_o[s]),
         .o_cfg   (w_cfg[s]),
         .o_dirty (w_dirty[s])
      );
   end

   assign no_oen_o = w_oen_o[SIDE_NO];
   assign so_oen_o = w_oen_o[SIDE_SO];
   assign ea_oen_o = w_oen_o[SIDE_EA];
   assign we_oen_o = w_oen_o[SIDE_WE];
   assign no_ie_o  = w_ie_o[SIDE_NO];
   assign so_ie_o  = w_ie_o[SIDE_SO];
   assign ea_ie_o  = w_ie_o[SIDE_EA];
   assign we_ie_o  = w_ie_o[SIDE_WE];
   assign no_cfg_o = w_cfg[SIDE_NO];
   assign so_cfg_o = w_cfg[SIDE_SO];
   assign ea_cfg_o = w_cfg[SIDE_EA];
   assign we_cfg_o = w_cfg[SIDE_WE];

`ifdef PAD_CFG_CTRL_READBACK_EN
   logic [CFGW-1:0] r_rd_cfg;
   logic [CFGW-1:0] w_rd_sel;

   always_comb begin
      w_rd_sel = '0;
      for (int p = 0; p < NGPIO; p++) begin
         if (rd_pad_i == 4'(p)) w_rd_sel = w_cfg[rd_side_i][p*CFGW +: CFGW];
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) r_rd_cfg <= '0;
      else r_rd_cfg <= w_rd_sel;
   end

   assign rd_cfg_o = r_rd_cfg;
`endif

endmodule

// File: tb/tb_pad_cfg_ctrl.sv
// Directed self-checking bench for pad_cfg_ctrl (SETTLE=4, NGPIO=9, CFGW=8).
module tb_pad_cfg_ctrl;

   localparam int NG = 9;
   localparam int CW = 8;

   logic           clk_i = 1'b0;
   logic           rst_i;
   logic           commit_i;
   logic           busy_o, done_o, err_o;
   logic [NG-1:0]  no_oen_i, so_oen_i, ea_oen_i, we_oen_i;
   logic [NG-1:0]  no_ie_i, so_ie_i, ea_ie_i, we_ie_i;
   logic [NG-1:0]  no_oen_o, so_oen_o, ea_oen_o, we_oen_o;
   logic [NG-1:0]  no_ie_o, so_ie_o, ea_ie_o, we_ie_o;
   logic [NG*CW-1:0] no_cfg_o, so_cfg_o, ea_cfg_o, we_cfg_o;
`ifdef PAD_CFG_CTRL_READBACK_EN
   logic [1:0]     rd_side_i;
   logic [3:0]     rd_pad_i;
   logic [CW-1:0]  rd_cfg_o;
`endif

   int n_cmp = 0;
   int n_bad = 0;

   pad_cfg_ctrl_if #(.CFGW(CW)) req_if ();

   pad_cfg_ctrl #(.NGPIO(NG), .CFGW(CW), .SETTLE(4)) dut (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .req      (req_if.slave),
      .commit_i (commit_i),
      .busy_o   (busy_o),
      .done_o   (done_o),
      .err_o    (err_o),
      .no_oen_i (no_oen_i),
      .so_oen_i (so_oen_i),
      .ea_oen_i (ea_oen_i),
      .we_oen_i (we_oen_i),
      .no_ie_i  (no_ie_i),
      .so_ie_i  (so_ie_i),
      .ea_ie_i  (ea_ie_i),
      .we_ie_i  (we_ie_i),
      .no_oen_o (no_oen_o),
      .so_oen_o (so_oen_o),
      .ea_oen_o (ea_oen_o),
      .we_oen_o (we_oen_o),
      .no_ie_o  (no_ie_o),
      .so_ie_o  (so_ie_o),
      .ea_ie_o  (ea_ie_o),
      .we_ie_o  (we_ie_o),
`ifdef PAD_CFG_CTRL_READBACK_EN
      .rd_side_i(rd_side_i),
      .rd_pad_i (rd_pad_i),
      .rd_cfg_o (rd_cfg_o),
`endif
      .no_cfg_o (no_cfg_o),
      .so_cfg_o (so_cfg_o),
      .ea_cfg_o (ea_cfg_o),
      .we_cfg_o (we_cfg_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic drive_wr(input logic [1:0] s, input logic [3:0] p,
                           input logic [7:0] c);
      req_if.req_valid_i = 1'b1;
      req_if.req_side_i  = s;
      req_if.req_pad_i   = p;
      req_if.req_cfg_i   = c;
   endtask

   task automatic test_reset();
      rst_i = 1'b1;
      step();
      step();
      rst_i = 1'b0;
      #1;
      n_cmp++;
      if (req_if.req_ready_o !== 1'b1) begin
         n_bad++;
         $display("FAIL reset_ready got %b want 1", req_if.req_ready_o);
      end
      n_cmp++;
      if ({busy_o, done_o, err_o} !== 3'b000) begin
         n_bad++;
         $display("FAIL reset_flags got %b want 000", {busy_o, done_o, err_o});
      end
      n_cmp++;
      if ({no_cfg_o, so_cfg_o, ea_cfg_o, we_cfg_o} !== '0) begin
         n_bad++;
         $display("FAIL reset_cfg got nonzero want 0");
      end
      n_cmp++;
      if (no_oen_o !== no_oen_i || we_ie_o !== we_ie_i) begin
         n_bad++;
         $display("FAIL reset_pass got %h/%h want %h/%h",
                  no_oen_o, we_ie_o, no_oen_i, we_ie_i);
      end
   endtask

   task automatic test_commit_no();
      logic [7:0] exp_cfg;
      drive_wr(2'd0, 4'd3, 8'hA5);
      step();
      req_if.req_valid_i = 1'b0;
      commit_i = 1'b1;
      step();
      commit_i = 1'b0;
      for (int k = 1; k <= 11; k++) begin
         exp_cfg = (k >= 6) ? 8'hA5 : 8'h00;
         n_cmp++;
         if (no_cfg_o[31:24] !== exp_cfg) begin
            n_bad++;
            $display("FAIL no_cfg k=%0d got %h want %h", k, no_cfg_o[31:24], exp_cfg);
         end
         n_cmp++;
         if (done_o !== (k == 10)) begin
            n_bad++;
            $display("FAIL no_done k=%0d got %b want %b", k, done_o, (k == 10));
         end
         n_cmp++;
         if (busy_o !== (k <= 10)) begin
            n_bad++;
            $display("FAIL no_busy k=%0d got %b want %b", k, busy_o, (k <= 10));
         end
         n_cmp++;
         if (no_oen_o !== ((k <= 9) ? 9'h1FF : no_oen_i) ||
             no_ie_o !== ((k <= 9) ? 9'h000 : no_ie_i)) begin
            n_bad++;
            $display("FAIL no_force k=%0d got %h/%h", k, no_oen_o, no_ie_o);
         end
         step();
      end
   endtask

   task automatic test_quiesce_ea();
      drive_wr(2'd2, 4'd0, 8'h11);
      step();
      req_if.req_valid_i = 1'b0;
      commit_i = 1'b1;
      step();
      commit_i = 1'b0;
      for (int k = 1; k <= 10; k++) begin
         n_cmp++;
         if (ea_oen_o !== ((k <= 9) ? 9'h1FF : ea_oen_i) ||
             ea_ie_o !== ((k <= 9) ? 9'h000 : ea_ie_i)) begin
            n_bad++;
            $display("FAIL ea_force k=%0d got %h/%h", k, ea_oen_o, ea_ie_o);
         end
         n_cmp++;
         if (no_oen_o !== no_oen_i || no_ie_o !== no_ie_i ||
             so_oen_o !== so_oen_i || so_ie_o !== so_ie_i ||
             we_oen_o !== we_oen_i || we_ie_o !== we_ie_i) begin
            n_bad++;
            $display("FAIL ea_others k=%0d got %h %h %h", k, no_oen_o, so_oen_o, we_oen_o);
         end
         n_cmp++;
         if (ea_cfg_o[7:0] !== ((k >= 6) ? 8'h11 : 8'h00)) begin
            n_bad++;
            $display("FAIL ea_cfg k=%0d got %h", k, ea_cfg_o[7:0]);
         end
         n_cmp++;
         if (done_o !== (k == 10)) begin
            n_bad++;
            $display("FAIL ea_done k=%0d got %b want %b", k, done_o, (k == 10));
         end
         step();
      end
   endtask

   task automatic test_err();
      drive_wr(2'd3, 4'd9, 8'hFF);
      step();
      req_if.req_valid_i = 1'b0;
      n_cmp++;
      if (err_o !== 1'b1) begin
         n_bad++;
         $display("FAIL err_set got %b want 1", err_o);
      end
      commit_i = 1'b1;
      step();
      commit_i = 1'b0;
      n_cmp++;
      if (done_o !== 1'b1 || busy_o !== 1'b1) begin
         n_bad++;
         $display("FAIL err_fastdone got %b/%b want 1/1", done_o, busy_o);
      end
      n_cmp++;
      if (we_oen_o !== we_oen_i) begin
         n_bad++;
         $display("FAIL err_pass got %h want %h", we_oen_o, we_oen_i);
      end
      step();
      n_cmp++;
      if (we_cfg_o !== '0 || req_if.req_ready_o !== 1'b1 || err_o !== 1'b1) begin
         n_bad++;
         $display("FAIL err_after got %h %b %b want 0 1 1",
                  we_cfg_o, req_if.req_ready_o, err_o);
      end
   endtask

   task automatic test_back_to_back();
      drive_wr(2'd1, 4'd0, 8'h3C);
      commit_i = 1'b1;
      step();
      req_if.req_valid_i = 1'b0;
      commit_i = 1'b0;
      for (int k = 1; k <= 10; k++) begin
         if (k == 1 || k == 6 || k == 10) begin
            n_cmp++;
            if (so_oen_o !== ((k <= 9) ? 9'h1FF : so_oen_i) ||
                so_cfg_o[7:0] !== ((k >= 6) ? 8'h3C : 8'h00) ||
                done_o !== (k == 10)) begin
               n_bad++;
               $display("FAIL b2b k=%0d got %h %h %b", k, so_oen_o, so_cfg_o[7:0], done_o);
            end
         end
         step();
      end
`ifdef PAD_CFG_CTRL_READBACK_EN
      rd_side_i = 2'd1;
      rd_pad_i  = 4'd0;
      step();
      n_cmp++;
      if (rd_cfg_o !== 8'h3C) begin
         n_bad++;
         $display("FAIL rd_so0 got %h want 3c", rd_cfg_o);
      end
      rd_side_i = 2'd0;
      rd_pad_i  = 4'd3;
      step();
      n_cmp++;
      if (rd_cfg_o !== 8'hA5) begin
         n_bad++;
         $display("FAIL rd_no3 got %h want a5", rd_cfg_o);
      end
      rd_pad_i = 4'd9;
      step();
      n_cmp++;
      if (rd_cfg_o !== 8'h00) begin
         n_bad++;
         $display("FAIL rd_oob got %h want 00", rd_cfg_o);
      end
`endif
   endtask

   task automatic test_reset_mid();
      drive_wr(2'd0, 4'd0, 8'h77);
      step();
      req_if.req_valid_i = 1'b0;
      commit_i = 1'b1;
      step();
      commit_i = 1'b0;
      for (int k = 1; k < 6; k++) step();
      n_cmp++;
      if (no_cfg_o !== 72'h0000000000A5000077 || no_oen_o !== 9'h1FF) begin
         n_bad++;
         $display("FAIL mid_release got %h %h", no_cfg_o, no_oen_o);
      end
      rst_i = 1'b1;
      step();
      rst_i = 1'b0;
      #1;
      n_cmp++;
      if ({no_cfg_o, so_cfg_o, ea_cfg_o, we_cfg_o} !== '0) begin
         n_bad++;
         $display("FAIL mid_cfg got %h %h want 0", no_cfg_o, so_cfg_o);
      end
      n_cmp++;
      if (no_oen_o !== no_oen_i || no_ie_o !== no_ie_i) begin
         n_bad++;
         $display("FAIL mid_pass got %h/%h want %h/%h", no_oen_o, no_ie_o, no_oen_i, no_ie_i);
      end
      n_cmp++;
      if (req_if.req_ready_o !== 1'b1 || busy_o !== 1'b0 || err_o !== 1'b0) begin
         n_bad++;
         $display("FAIL mid_state got %b %b %b want 1 0 0",
                  req_if.req_ready_o, busy_o, err_o);
      end
      step();
      n_cmp++;
      if (done_o !== 1'b0 || busy_o !== 1'b0) begin
         n_bad++;
         $display("FAIL mid_after got %b/%b want 0/0", done_o, busy_o);
      end
   endtask

   initial begin
      rst_i    = 1'b1;
      commit_i = 1'b0;
      req_if.req_valid_i = 1'b0;
      req_if.req_side_i  = 2'd0;
      req_if.req_pad_i   = 4'd0;
      req_if.req_cfg_i   = 8'h00;
      no_oen_i = 9'h0F0; no_ie_i = 9'h10F;
      so_oen_i = 9'h055; so_ie_i = 9'h1AA;
      ea_oen_i = 9'h133; ea_ie_i = 9'h0CC;
      we_oen_i = 9'h0E1; we_ie_i = 9'h11E;
`ifdef PAD_CFG_CTRL_READBACK_EN
      rd_side_i = 2'd0;
      rd_pad_i  = 4'd0;
`endif
      test_reset();
      test_commit_no();
      test_quiesce_ea();
      test_err();
      test_back_to_back();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
